// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round sequencer and its neighbours.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [3:0]   aes_round_t;

    // Sequencer control states: one AES round is KEY -> SS -> MC, the last round skips MC.
    typedef enum logic [2:0] {
        IDLE,
        KEY,
        SS,
        MC,
        DONE
    } seq_state_e;

    localparam int AES_NR_128 = 10;

    // AddRoundKey is a plain XOR of state and round key.
    function automatic aes_block_t add_round_key(input aes_block_t blk, input aes_block_t rk);
        return blk ^ rk;
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: owns the 128-bit state register and walks one block through
// AddRoundKey, SubBytes/ShiftRows (external, combinational) and MixColumns (external,
// req/ack) for NR rounds, fetching each round key over a req/ack port.
// The final round bypasses MixColumns. A MixColumns core that never answers is
// abandoned after MC_TIMEOUT cycles with a sticky error.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR         = AES_NR_128,
    parameter int MC_TIMEOUT = 255
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic         start_i,
    input  logic [127:0] plaintext_i,
    output logic         ready_o,
    output logic         done_o,
    output logic         error_o,
    output logic [127:0] ciphertext_o,
    output logic [3:0]   round_o,
    output logic         key_req_o,
    output logic [3:0]   key_round_o,
    input  logic         key_ack_i,
    input  logic [127:0] key_i,
    output logic [127:0] ss_in_o,
    input  logic [127:0] ss_out_i,
    output logic         mc_req_o,
    output logic [127:0] mc_data_o,
    input  logic         mc_ack_i,
    input  logic [127:0] mc_data_i
);

    // The wait counter only has to reach MC_TIMEOUT-1.
    localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MC_TIMEOUT - 1);
    localparam aes_round_t       ROUND_LAST = aes_round_t'(NR);

    seq_state_e       fsm;
    seq_state_e       nxt_fsm;
    aes_block_t       blk;
    aes_block_t       nxt_blk;
    aes_round_t       round;
    aes_round_t       nxt_round;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_err;
    aes_block_t       nxt_ct;
    aes_block_t       keyed_blk;

    // Both datapath cores see the state register directly; only meaningful in SS / MC.
    assign ss_in_o   = blk;
    assign mc_data_o = blk;
    assign round_o   = round;
    assign keyed_blk = add_round_key(blk, key_i);

    // Next-state decode: FSM transitions, state register moves, round and wait counters.
    always_comb begin
        nxt_fsm   = fsm;
        nxt_blk   = blk;
        nxt_round = round;
        nxt_cnt   = cnt;
        nxt_err   = error_o;
        nxt_ct    = ciphertext_o;
        case (fsm)
            IDLE: begin
                if (start_i) begin
                    nxt_blk   = plaintext_i;
                    nxt_round = '0;
                    nxt_cnt   = '0;
                    nxt_err   = 1'b0;
                    nxt_fsm   = KEY;
                end
            end
            KEY: begin
                if (key_ack_i) begin
                    nxt_blk = keyed_blk;
                    if (round == ROUND_LAST) begin
                        // Publish the result together with the done pulse.
                        nxt_ct  = keyed_blk;
                        nxt_fsm = DONE;
                    end else begin
                        nxt_round = round + 1'b1;
                        nxt_fsm   = SS;
                    end
                end
            end
            SS: begin
                nxt_blk = ss_out_i;
                nxt_fsm = (round == ROUND_LAST) ? KEY : MC;
            end
            MC: begin
                if (mc_ack_i) begin
                    nxt_blk = mc_data_i;
                    nxt_cnt = '0;
                    nxt_fsm = KEY;
                end else if (cnt == CNT_LAST) begin
                    // Give up on the core; the previous ciphertext stays visible.
                    nxt_err = 1'b1;
                    nxt_cnt = '0;
                    nxt_fsm = IDLE;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            DONE: begin
                nxt_fsm = IDLE;
            end
            default: begin
                nxt_fsm = IDLE;
            end
        endcase
    end

    // State/control registers; handshake and status outputs are registered from the next state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            fsm          <= IDLE;
            blk          <= '0;
            round        <= '0;
            cnt          <= '0;
            ready_o      <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            ciphertext_o <= '0;
            key_req_o    <= 1'b0;
            key_round_o  <= '0;
            mc_req_o     <= 1'b0;
        end else begin
            fsm          <= nxt_fsm;
            blk          <= nxt_blk;
            round        <= nxt_round;
            cnt          <= nxt_cnt;
            error_o      <= nxt_err;
            ciphertext_o <= nxt_ct;
            ready_o      <= (nxt_fsm == IDLE);
            done_o       <= (nxt_fsm == DONE);
            key_req_o    <= (nxt_fsm == KEY);
            key_round_o  <= nxt_round;
            mc_req_o     <= (nxt_fsm == MC);
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: golden AES round functions and key schedule act as the
// external cores; a block-level AES model supplies the expected operands and results.
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam int MCT = 8;

    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         start_i;
    logic [127:0] plaintext_i;
    logic         ready_o;
    logic         done_o;
    logic         error_o;
    logic [127:0] ciphertext_o;
    logic [3:0]   round_o;
    logic         key_req_o;
    logic [3:0]   key_round_o;
    logic         key_ack_i;
    logic [127:0] key_i;
    logic [127:0] ss_in_o;
    logic [127:0] ss_out_i;
    logic         mc_req_o;
    logic [127:0] mc_data_o;
    logic         mc_ack_i;
    logic [127:0] mc_data_i;

    int compared   = 0;
    int mismatched = 0;

    logic [127:0] rk [0:NR];
    logic [127:0] exp_mc_in [0:NR];
    logic [127:0] exp_ct;
    int  key_idx_exp = 0;
    int  mc_idx_exp  = 0;
    int  done_cnt    = 0;
    bit  rand_dly    = 0;
    bit  mc_mute     = 0;
    bit  mon_en      = 0;

    aes_round_sequencer #(.NR(NR), .MC_TIMEOUT(MCT)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start_i(start_i), .plaintext_i(plaintext_i),
        .ready_o(ready_o), .done_o(done_o), .error_o(error_o), .ciphertext_o(ciphertext_o),
        .round_o(round_o), .key_req_o(key_req_o), .key_round_o(key_round_o),
        .key_ack_i(key_ack_i), .key_i(key_i), .ss_in_o(ss_in_o), .ss_out_i(ss_out_i),
        .mc_req_o(mc_req_o), .mc_data_o(mc_data_o), .mc_ack_i(mc_ack_i), .mc_data_i(mc_data_i)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[8*(15 - int'(b[3:0])) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of a block is row i%4, column i/4; byte 0 is the most significant.
    function automatic logic [127:0] sub_shift(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127 - 8*(r + 4*c) -: 8] = sbox(x[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0] a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127 - 32*c -: 8];
            a1 = x[119 - 32*c -: 8];
            a2 = x[111 - 32*c -: 8];
            a3 = x[103 - 32*c -: 8];
            y[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            y[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            y[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            y[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return y;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Key schedule plus a straight-line AES encryption recording every MixColumns operand.
    task automatic setup_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [0:4*NR+3];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [127:0] s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 4*NR + 4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) begin
            s = sub_shift(s);
            if (r < NR) begin
                exp_mc_in[r] = s;
                s = mix_columns(s);
            end
            s = s ^ rk[r];
        end
        exp_ct      = s;
        key_idx_exp = 0;
        mc_idx_exp  = 0;
    endtask

    // SubBytes/ShiftRows core: purely combinational.
    always_comb ss_out_i = sub_shift(ss_in_o);

    // Round-key responder: answers each request after 0 or a random 0..7 cycle delay.
    initial begin : key_resp
        int d;
        d = -1;
        key_ack_i = 1'b0;
        key_i = '0;
        forever begin
            @(posedge ACLK);
            #1;
            key_ack_i = 1'b0;
            key_i = {$urandom, $urandom, $urandom, $urandom};
            if (key_req_o) begin
                if (d < 0) d = rand_dly ? int'($urandom_range(0, 7)) : 0;
                if (d == 0) begin
                    key_ack_i = 1'b1;
                    key_i = rk[key_round_o];
                    d = -1;
                end else begin
                    d--;
                end
            end else begin
                d = -1;
            end
        end
    end

    // MixColumns responder: same delay scheme, can be muted to force a timeout.
    initial begin : mc_resp
        int d;
        d = -1;
        mc_ack_i = 1'b0;
        mc_data_i = '0;
        forever begin
            @(posedge ACLK);
            #1;
            mc_ack_i = 1'b0;
            mc_data_i = {$urandom, $urandom, $urandom, $urandom};
            if (mc_req_o && !mc_mute) begin
                if (d < 0) d = rand_dly ? int'($urandom_range(0, 7)) : 0;
                if (d == 0) begin
                    mc_ack_i = 1'b1;
                    mc_data_i = mix_columns(mc_data_o);
                    d = -1;
                end else begin
                    d--;
                end
            end else begin
                d = -1;
            end
        end
    end

    // Per-cycle compare against the model: handshake order, operand values, hold rules, result.
    initial begin : monitor
        logic pk_req, pk_ack, pm_req, pm_ack, p_done;
        logic [3:0] pk_rnd;
        logic [127:0] pm_data;
        pk_req = 0; pk_ack = 0; pm_req = 0; pm_ack = 0; p_done = 0; pk_rnd = '0; pm_data = '0;
        forever begin
            @(negedge ACLK);
            if (mon_en && !ARESET) begin
                if (pk_req && !pk_ack) begin
                    chk("key_req_hold", key_req_o, 1'b1);
                    chk("key_round_hold", key_round_o, pk_rnd);
                end
                if (pm_req && !pm_ack && !error_o) begin
                    chk("mc_req_hold", mc_req_o, 1'b1);
                    chk("mc_data_hold", mc_data_o, pm_data);
                end
                if (key_req_o && key_ack_i) begin
                    chk("key_round_order", key_round_o, key_idx_exp);
                    key_idx_exp++;
                end
                if (mc_req_o && mc_ack_i) begin
                    if (mc_idx_exp < NR - 1) chk("mc_operand", mc_data_o, exp_mc_in[mc_idx_exp + 1]);
                    else chk("mc_handshake_excess", mc_idx_exp + 1, NR - 1);
                    mc_idx_exp++;
                end
                if (done_o) begin
                    chk("done_ciphertext", ciphertext_o, exp_ct);
                    chk("done_error", error_o, 1'b0);
                    chk("done_single_pulse", p_done, 1'b0);
                    done_cnt++;
                end
                chk("round_le_nr", (round_o <= 4'(NR)), 1'b1);
                pk_req = key_req_o; pk_ack = key_ack_i; pk_rnd = key_round_o;
                pm_req = mc_req_o; pm_ack = mc_ack_i; pm_data = mc_data_o; p_done = done_o;
            end else begin
                pk_req = 0; pk_ack = 0; pm_req = 0; pm_ack = 0; p_done = 0;
            end
        end
    end

    // One encryption: wait for ready, start, wait (bounded) for done_o, check the outcome.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct_lit,
                             input bit rnd, input bit spam, input bit chk_lat, input string tag);
        int cyc;
        bit seen;
        int dn0;
        setup_model(key, pt);
        chk({tag, "_model_ct"}, exp_ct, ct_lit);
        rand_dly = rnd;
        dn0 = done_cnt;
        @(negedge ACLK);
        cyc = 0;
        while (!ready_o && cyc < 100) begin
            @(negedge ACLK);
            cyc++;
        end
        chk({tag, "_ready_before_start"}, ready_o, 1'b1);
        start_i = 1'b1;
        plaintext_i = pt;
        @(negedge ACLK);
        cyc = 1;
        if (!spam) begin
            start_i = 1'b0;
            plaintext_i = {$urandom, $urandom, $urandom, $urandom};
        end
        seen = 0;
        while (cyc < 2000) begin
            if (done_o) begin
                seen = 1;
                break;
            end
            if (spam) plaintext_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge ACLK);
            cyc++;
        end
        start_i = 1'b0;
        chk({tag, "_done_seen"}, seen, 1'b1);
        if (chk_lat) chk({tag, "_latency"}, cyc, 3*NR + 1);
        chk({tag, "_ciphertext"}, ciphertext_o, ct_lit);
        chk({tag, "_error_clear"}, error_o, 1'b0);
        chk({tag, "_not_ready_in_done"}, ready_o, 1'b0);
        #2;
        chk({tag, "_done_count"}, done_cnt, dn0 + 1);
        chk({tag, "_key_handshakes"}, key_idx_exp, NR + 1);
        chk({tag, "_mc_handshakes"}, mc_idx_exp, NR - 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        int mcc;
        int dn0;
        ARESET = 1'b1;
        start_i = 1'b0;
        plaintext_i = '0;

        // Reset state.
        #3;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_key_req", key_req_o, 1'b0);
        chk("rst_mc_req", mc_req_o, 1'b0);
        chk("rst_ciphertext", ciphertext_o, 128'h0);
        chk("rst_rounds", {round_o, key_round_o}, 8'h00);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("idle_ready", ready_o, 1'b1);

        // Pin the model to published FIPS-197 values.
        setup_model(K1, PT1);
        chk("model_rk10", rk[NR], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_ct1", exp_ct, CT1);
        setup_model(K2, PT2);
        chk("model_ct2", exp_ct, CT2);
        mon_en = 1;

        // Zero-wait acks, then random handshake delays.
        run_block(PT1, K1, CT1, 1'b0, 1'b0, 1'b1, "zero_wait");
        run_block(PT1, K1, CT1, 1'b1, 1'b0, 1'b0, "random_wait");

        // start_i held high during the whole operation, including the done cycle.
        run_block(PT1, K1, CT1, 1'b0, 1'b1, 1'b1, "start_spam");
        @(negedge ACLK);
        @(negedge ACLK);
        chk("spam_no_restart", {ready_o, key_req_o}, 2'b10);

        // Back-to-back: second start in the cycle right after done_o.
        run_block(PT1, K1, CT1, 1'b0, 1'b0, 1'b1, "b2b_first");
        run_block(PT2, K2, CT2, 1'b0, 1'b0, 1'b1, "b2b_second");

        // MixColumns never acknowledges: abort after MCT cycles.
        setup_model(K1, PT1);
        mc_mute = 1;
        rand_dly = 0;
        dn0 = done_cnt;
        @(negedge ACLK);
        start_i = 1'b1;
        plaintext_i = PT1;
        @(negedge ACLK);
        start_i = 1'b0;
        mcc = 0;
        cyc = 0;
        while (!error_o && cyc < 200) begin
            if (mc_req_o) mcc++;
            @(negedge ACLK);
            cyc++;
        end
        chk("timeout_error", error_o, 1'b1);
        chk("timeout_mc_cycles", mcc, MCT);
        chk("timeout_ready", ready_o, 1'b1);
        chk("timeout_mc_req_low", mc_req_o, 1'b0);
        chk("timeout_ct_held", ciphertext_o, CT2);
        @(negedge ACLK);
        chk("timeout_error_sticky", error_o, 1'b1);
        chk("timeout_no_done", done_cnt, dn0);
        mc_mute = 0;
        run_block(PT1, K1, CT1, 1'b1, 1'b0, 1'b0, "after_timeout");

        // Asynchronous reset in the middle of round 5.
        setup_model(K1, PT1);
        rand_dly = 0;
        dn0 = done_cnt;
        @(negedge ACLK);
        start_i = 1'b1;
        plaintext_i = PT1;
        @(negedge ACLK);
        start_i = 1'b0;
        cyc = 0;
        while (round_o != 4'd5 && cyc < 200) begin
            @(negedge ACLK);
            cyc++;
        end
        chk("reset_reached_round5", round_o, 4'd5);
        mon_en = 0;
        #1;
        ARESET = 1'b1;
        #1;
        chk("midrst_ready", ready_o, 1'b1);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_reqs", {key_req_o, mc_req_o}, 2'b00);
        chk("midrst_rounds", {round_o, key_round_o}, 8'h00);
        chk("midrst_ciphertext", ciphertext_o, 128'h0);
        chk("midrst_state", mc_data_o, 128'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("midrst_no_done", done_cnt, dn0);
        mon_en = 1;
        run_block(PT2, K2, CT2, 1'b1, 1'b0, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
